cpu_execute_unit: RTL and testbench
===================================

# cpu_execute_unit

Multi-cycle execute stage between the operand read ports and the write port of the CPU register file. It captures the two operand buses, performs one of eight ALU/multiply operations, and drives the register-file write-data and write-select inputs for exactly one writeback cycle. Single-cycle operations use an issue/writeback sequence. Multiply is an iterative 32-step shift-add sequence with a READY/START handshake toward the control unit.

## Interface
- WIDTH, 32: datapath width. Only 32 is supported.
- IDLE_WR_SEL, 4'hF: write-select value driven when not writing. Decoder output 15 is unconnected, so this value performs no write.

- CLK  in  1  single clock, rising edge
- ACLR_N  in  1  asynchronous, active-low reset
- START  in  1  issue request; sampled only when READY=1
- OPCODE  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
- DEST_SEL  in  4  destination register index 0-15
- OP0_IN  in  32  operand A (from register-file OP0_OUT_BUS)
- OP1_IN  in  32  operand B (from register-file OP1_OUT_BUS)
- READY  out  1  unit idle, START will be accepted
- REG_INPUT_BUS  out  32  write data to register file
- REG_WR_SEL  out  4  write select to register file
- DONE  out  1  one-cycle pulse, coincident with the writeback cycle
- FLAGS  out  4  {Z,N,C,V}, registered, updated only at writeback

## Operation
- States: IDLE, MUL, WB.
- IDLE: READY=1. On START=1, capture OPCODE, DEST_SEL, OP0_IN and OP1_IN.
  - Non-MUL opcode: compute the result into the result register, go to WB.
  - MUL: clear the accumulator, load the multiplicand/multiplier shift registers, clear the step counter, go to MUL.
- MUL: each cycle, if multiplier LSB=1 then accumulator += multiplicand (mod 2^32). Shift multiplicand left 1, multiplier right 1, counter += 1. After step 31 (counter wraps 31->0), go to WB. Result = low 32 bits of the unsigned product.
- WB: REG_INPUT_BUS=result, REG_WR_SEL=captured DEST_SEL, DONE=1, FLAGS updated, READY=0. Next state is always IDLE.
- Arithmetic rules:
  - ADD: 33-bit sum. C=bit 32. V=(A31==B31)&&(R31!=A31).
  - SUB: R=A-B. C=1 when A>=B unsigned (no borrow). V=(A31!=B31)&&(R31!=A31).
  - SLL/SRL: shift amount OP1[4:0], logical, zero fill.
  - Logic, shifts, MUL: C=0, V=0.
  - All ops: Z=(R==0), N=R[31].
- DEST_SEL=15: the operation completes normally and DONE and FLAGS update, but REG_WR_SEL=15, so no register is written. The PC is never written by this unit.
- START while READY=0 is ignored; no queuing.
- Outside WB: REG_WR_SEL=IDLE_WR_SEL and DONE=0. REG_INPUT_BUS holds its last value.
- REG_WR_SEL, REG_INPUT_BUS, DONE and FLAGS are driven directly from flops, so the decoder enable cannot glitch.
- Operands are sampled only at the accept edge. Changes on OP0_IN/OP1_IN afterwards have no effect.

## Timing
- Reset (ACLR_N=0, asynchronous): state=IDLE, READY=1, REG_INPUT_BUS=0, REG_WR_SEL=4'hF, DONE=0, FLAGS=0, counter=0.
- Reset asserted mid-MUL or during WB: the operation aborts immediately with no write. First accept is possible on the first rising edge after ACLR_N deasserts.
- Non-MUL: START accepted at edge k → WB during cycle k..k+1, with the register written at edge k+1 → READY=1 from edge k+1. Back-to-back issue gives 1 op per 2 cycles.
- MUL: accept at edge k → MUL for 32 cycles → WB cycle begins at edge k+32 → write and READY=1 at edge k+33.
- DONE is high for exactly one cycle per accepted START.
- A START held high across WB is re-accepted at the first IDLE cycle. The control unit must deassert START on the cycle after accept to avoid a duplicate issue.

## Test plan
- Reset then idle: ACLR_N low → READY=1, REG_WR_SEL=F, REG_INPUT_BUS=0, FLAGS=0. No DONE for 10 idle cycles.
- ADD overflow: A=7FFFFFFF, B=1, DEST=3 → next cycle REG_WR_SEL=3, data=80000000, FLAGS Z0 N1 C0 V1. DONE pulses for 1 cycle.
- SUB equal and borrow:
  - 5-5 → data 0, Z1 C1.
  - 3-5 → data FFFFFFFE, N1 C0 V0.
- MUL: A=0001_0003, B=0000_0005, DEST=14 → exactly 32 cycles of READY=0 before WB, then data 0005_000F. Also FFFFFFFF×FFFFFFFF → 00000001.
- Shift and discard:
  - SLL A=1, B=0000_0024 (amount 4) → 00000010.
  - Same op with DEST=15 → DONE=1, REG_WR_SEL stays F.
- Reset mid-MUL at step 10 → REG_WR_SEL=F throughout, no DONE, READY=1 immediately. A new ADD issued after deassert completes correctly.

Source files
------------

// File: rtl/cpu_execute_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops plus a 32-step shift-add multiply,
// with one registered writeback cycle toward the register file.
module cpu_execute_unit #(
  parameter int         WIDTH       = 32,
  parameter logic [3:0] IDLE_WR_SEL = 4'hF
) (
  input  logic             CLK,
  input  logic             ACLR_N,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [3:0]       DEST_SEL,
  input  logic [WIDTH-1:0] OP0_IN,
  input  logic [WIDTH-1:0] OP1_IN,
  output logic             READY,
  output logic [WIDTH-1:0] REG_INPUT_BUS,
  output logic [3:0]       REG_WR_SEL,
  output logic             DONE,
  output logic [3:0]       FLAGS
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_MUL = 3'd7;

  state_t           state_q;
  logic             ready_q, done_q;
  logic [3:0]       wr_sel_q, dest_q, flags_q;
  logic [WIDTH-1:0] data_q, acc_q, mcand_q, mplier_q;
  logic [4:0]       cnt_q;

  logic [WIDTH:0]   sum_d, diff_d;
  logic [WIDTH-1:0] alu_res_d, acc_d;
  logic             alu_c_d, alu_v_d;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    return {r == '0, r[WIDTH-1], c, v};
  endfunction

  always_comb begin
    sum_d     = {1'b0, OP0_IN} + {1'b0, OP1_IN};
    diff_d    = {1'b0, OP0_IN} - {1'b0, OP1_IN};
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    case (OPCODE)
      OP_ADD: begin
        alu_res_d = sum_d[WIDTH-1:0];
        alu_c_d   = sum_d[WIDTH];
        alu_v_d   = (OP0_IN[WIDTH-1] == OP1_IN[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != OP0_IN[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_d[WIDTH-1:0];
        alu_c_d   = ~diff_d[WIDTH];  // no borrow means A >= B
        alu_v_d   = (OP0_IN[WIDTH-1] != OP1_IN[WIDTH-1]) &&
                    (alu_res_d[WIDTH-1] != OP0_IN[WIDTH-1]);
      end
      OP_AND:  alu_res_d = OP0_IN & OP1_IN;
      OP_OR:   alu_res_d = OP0_IN | OP1_IN;
      OP_XOR:  alu_res_d = OP0_IN ^ OP1_IN;
      OP_SLL:  alu_res_d = OP0_IN << OP1_IN[4:0];
      OP_SRL:  alu_res_d = OP0_IN >> OP1_IN[4:0];
      default: alu_res_d = '0;
    endcase
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      wr_sel_q <= IDLE_WR_SEL;
      dest_q   <= '0;
      flags_q  <= '0;
      data_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      wr_sel_q <= IDLE_WR_SEL;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            ready_q <= 1'b0;
            if (OPCODE == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= OP0_IN;
              mplier_q <= OP1_IN;
              cnt_q    <= '0;
              dest_q   <= DEST_SEL;
              state_q  <= S_MUL;
            end else begin
              data_q   <= alu_res_d;
              wr_sel_q <= DEST_SEL;
              done_q   <= 1'b1;
              flags_q  <= mk_flags(alu_res_d, alu_c_d, alu_v_d);
              state_q  <= S_WB;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            data_q   <= acc_d;
            wr_sel_q <= dest_q;
            done_q   <= 1'b1;
            flags_q  <= mk_flags(acc_d, 1'b0, 1'b0);
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign READY         = ready_q;
  assign DONE          = done_q;
  assign REG_WR_SEL    = wr_sel_q;
  assign REG_INPUT_BUS = data_q;
  assign FLAGS         = flags_q;

endmodule

// File: tb/tb_cpu_execute_unit.sv
// Directed bench for cpu_execute_unit: hand-computed results, flags, latency and reset abort.
module tb_cpu_execute_unit;
  logic        CLK = 1'b0;
  logic        ACLR_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OPCODE = '0;
  logic [3:0]  DEST_SEL = '0;
  logic [31:0] OP0_IN = '0, OP1_IN = '0;
  logic        READY, DONE;
  logic [31:0] REG_INPUT_BUS;
  logic [3:0]  REG_WR_SEL, FLAGS;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_execute_unit dut (
    .CLK(CLK), .ACLR_N(ACLR_N), .START(START), .OPCODE(OPCODE), .DEST_SEL(DEST_SEL),
    .OP0_IN(OP0_IN), .OP1_IN(OP1_IN), .READY(READY), .REG_INPUT_BUS(REG_INPUT_BUS),
    .REG_WR_SEL(REG_WR_SEL), .DONE(DONE), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op, waits for writeback, checks it and the return to idle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] dest,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic [3:0] expf);
    int cycles;
    @(negedge CLK);
    START = 1'b1; OPCODE = op; DEST_SEL = dest; OP0_IN = a; OP1_IN = b;
    @(negedge CLK);
    START = 1'b0;
    OP0_IN = $urandom; OP1_IN = $urandom; OPCODE = 3'd0; DEST_SEL = 4'd1;
    cycles = 0;
    while (!DONE && cycles < 100) begin
      if (cycles == 3) START = 1'b1;
      if (cycles == 4) START = 1'b0;
      cycles++;
      @(negedge CLK);
    end
    check({tag, " latency"}, 32'(cycles), (op == 3'd7) ? 32'd32 : 32'd0);
    check({tag, " done"},  32'(DONE), 32'd1);
    check({tag, " data"},  REG_INPUT_BUS, exp);
    check({tag, " sel"},   32'(REG_WR_SEL), 32'(dest));
    check({tag, " flags"}, 32'(FLAGS), 32'(expf));
    check({tag, " ready_wb"}, 32'(READY), 32'd0);
    @(negedge CLK);
    check({tag, " done_drop"}, 32'(DONE), 32'd0);
    check({tag, " ready_after"}, 32'(READY), 32'd1);
    check({tag, " sel_idle"}, 32'(REG_WR_SEL), 32'hF);
    check({tag, " data_hold"}, REG_INPUT_BUS, exp);
  endtask

  initial begin
    int bad;
    #12;
    check("rst ready", 32'(READY), 32'd1);
    check("rst sel",   32'(REG_WR_SEL), 32'hF);
    check("rst data",  REG_INPUT_BUS, 32'd0);
    check("rst flags", 32'(FLAGS), 32'd0);
    check("rst done",  32'(DONE), 32'd0);
    @(negedge CLK);
    ACLR_N = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (DONE || REG_WR_SEL != 4'hF || !READY) bad++;
    end
    check("idle quiet", 32'(bad), 32'd0);

    run_op("add_ovf",  3'd0, 4'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101);
    run_op("add_cry",  3'd0, 4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010);
    run_op("sub_eq",   3'd1, 4'd4,  32'd5,        32'd5,        32'h00000000, 4'b1010);
    run_op("sub_brw",  3'd1, 4'd5,  32'd3,        32'd5,        32'hFFFFFFFE, 4'b0100);
    run_op("sub_ovf",  3'd1, 4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
    run_op("and",      3'd2, 4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100);
    run_op("or_zero",  3'd3, 4'd8,  32'h00000000, 32'h00000000, 32'h00000000, 4'b1000);
    run_op("xor",      3'd4, 4'd9,  32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 4'b0000);
    run_op("sll",      3'd5, 4'd10, 32'h00000001, 32'h00000024, 32'h00000010, 4'b0000);
    run_op("srl",      3'd6, 4'd11, 32'h80000000, 32'h0000003F, 32'h00000001, 4'b0000);
    run_op("mul",      3'd7, 4'd14, 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000);
    run_op("mul_ff",   3'd7, 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000);
    run_op("add_neg",  3'd0, 4'd1,  32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 4'b0100);
    run_op("sll_disc", 3'd5, 4'd15, 32'h00000001, 32'h00000024, 32'h00000010, 4'b0000);

    // Reset during multiply step 10 must abort without a write.
    @(negedge CLK);
    START = 1'b1; OPCODE = 3'd7; DEST_SEL = 4'd6; OP0_IN = 32'd7; OP1_IN = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    check("abort busy", 32'(READY), 32'd0);
    ACLR_N = 1'b0;
    #1;
    check("abort ready", 32'(READY), 32'd1);
    check("abort sel",   32'(REG_WR_SEL), 32'hF);
    check("abort done",  32'(DONE), 32'd0);
    @(negedge CLK);
    ACLR_N = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE || REG_WR_SEL != 4'hF || !READY) bad++;
    end
    check("abort quiet", 32'(bad), 32'd0);
    run_op("add_post", 3'd0, 4'd3, 32'h00000010, 32'h00000022, 32'h00000032, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
